// File: rtl/rob_pkg.sv
// rob_pkg: shared definitions for the in-order retirement buffer.
//   ROB_DEPTH   default number of buffer entries (power of two, >= 2)
//   ROB_TAG_W   width of an entry tag for the default depth
//   rob_entry_t per-entry state: busy, done, destination register, result
package rob_pkg;

   localparam int ROB_DEPTH = 8;
   localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

   typedef struct packed {
      logic        busy;  // entry allocated and not yet retired
      logic        done;  // result has been written back
      logic [4:0]  rd;    // architectural destination register
      logic [31:0] data;  // result value
   } rob_entry_t;

endpackage

// File: rtl/rob_commit.sv
// rob_commit: in-order retirement buffer feeding the register file write port.
// Dispatch allocates an entry at the tail, out-of-order writeback fills
// entries by tag, and the oldest completed entry retires through a
// registered output stage, at most one per cycle.
// Ports:
//   clk                  clock, all state changes on the rising edge
//   rst                  asynchronous reset, active low
//   alloc_valid/alloc_rd allocation request and its destination register
//   alloc_ready          an entry is free (from registered count only)
//   alloc_tag            tag handed to the allocating instruction (tail)
//   wb_valid/wb_tag/wb_data  writeback of a result into an entry
//   flush                discard every in-flight entry
//   reg_write/wa/data_write  registered register file write port
//   commit_valid         one-cycle pulse per retired entry (also for x0)
//   count                number of occupied entries
module rob_commit
   import rob_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_valid,
   input  logic [4:0]       alloc_rd,
   output logic             alloc_ready,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             wb_valid,
   input  logic [TAG_W-1:0] wb_tag,
   input  logic [31:0]      wb_data,
   input  logic             flush,
   output logic             reg_write,
   output logic [4:0]       wa,
   output logic [31:0]      data_write,
   output logic             commit_valid,
   output logic [TAG_W:0]   count
);

   localparam logic [TAG_W:0]   DEPTH_CNT = (TAG_W+1)'(DEPTH);
   localparam logic [TAG_W:0]   CNT_ONE   = (TAG_W+1)'(1);
   localparam logic [TAG_W-1:0] PTR_ONE   = TAG_W'(1);

   rob_entry_t       ent_q [DEPTH];
   rob_entry_t       ent_d [DEPTH];
   logic [TAG_W-1:0] head_q, head_d;
   logic [TAG_W-1:0] tail_q, tail_d;
   logic [TAG_W:0]   count_q, count_d;
   logic             reg_write_q, reg_write_d;
   logic [4:0]       wa_q, wa_d;
   logic [31:0]      data_write_q, data_write_d;
   logic             commit_valid_q, commit_valid_d;

   logic             alloc_fire;
   logic             commit_fire;

   // Readiness looks only at the registered count, so a slot freed by a
   // commit in this cycle cannot be reused until the next one.
   assign alloc_ready = (count_q < DEPTH_CNT);
   assign alloc_tag   = tail_q;
   assign alloc_fire  = alloc_valid && alloc_ready;
   // A busy head implies a non-empty buffer, so no separate empty test.
   assign commit_fire = ent_q[head_q].busy && ent_q[head_q].done;

   always_comb begin
      ent_d          = ent_q;
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      reg_write_d    = 1'b0;
      commit_valid_d = 1'b0;
      wa_d           = wa_q;
      data_write_d   = data_write_q;

      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_d[i].busy = 1'b0;
            ent_d[i].done = 1'b0;
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         // Writeback to an idle entry is silently dropped.
         if (wb_valid && ent_q[wb_tag].busy) begin
            ent_d[wb_tag].done = 1'b1;
            ent_d[wb_tag].data = wb_data;
         end

         if (alloc_fire) begin
            ent_d[tail_q].busy = 1'b1;
            ent_d[tail_q].done = 1'b0;
            ent_d[tail_q].rd   = alloc_rd;
            tail_d             = tail_q + PTR_ONE;
         end

         // Retirement is applied last so it always clears the head entry.
         if (commit_fire) begin
            ent_d[head_q].busy = 1'b0;
            ent_d[head_q].done = 1'b0;
            head_d             = head_q + PTR_ONE;
            commit_valid_d     = 1'b1;
            reg_write_d        = (ent_q[head_q].rd != 5'd0);
            wa_d               = ent_q[head_q].rd;
            data_write_d       = ent_q[head_q].data;
         end

         if (alloc_fire && !commit_fire) begin
            count_d = count_q + CNT_ONE;
         end else if (!alloc_fire && commit_fire) begin
            count_d = count_q - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         reg_write_q    <= 1'b0;
         wa_q           <= '0;
         data_write_q   <= '0;
         commit_valid_q <= 1'b0;
      end else begin
         ent_q          <= ent_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         reg_write_q    <= reg_write_d;
         wa_q           <= wa_d;
         data_write_q   <= data_write_d;
         commit_valid_q <= commit_valid_d;
      end
   end

   assign reg_write    = reg_write_q;
   assign wa           = wa_q;
   assign data_write   = data_write_q;
   assign commit_valid = commit_valid_q;
   assign count        = count_q;

endmodule
